// File: rtl/ahb3lite_pkg.sv
// rtl/ahb3lite_pkg.sv - shared AHB3-Lite encodings and slave FSM state type
// Purpose: transfer-type enum, HSIZE codes, HRESP codes and the SRAM slave
//          state typedef, imported by every file of the slave.
// Ports:   none (package).
package ahb3lite_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'd0,
        HTRANS_BUSY   = 2'd1,
        HTRANS_NONSEQ = 2'd2,
        HTRANS_SEQ    = 2'd3
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HWORD = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } slave_state_t;

endpackage

// File: rtl/ahb3lite_sram_bank.sv
// rtl/ahb3lite_sram_bank.sv - byte-enable synchronous RAM with registered read
// Purpose: MEM_DEPTH x HDATA_SIZE storage, one lane-masked write port and one
//          registered read port (data appears the cycle after re).
// Ports:   clk; we/waddr/wmask/wdata write port; re/raddr read request;
//          rdata registered read data, held until the next re.
module ahb3lite_sram_bank #(
    parameter int HDATA_SIZE = 32,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [$clog2(MEM_DEPTH)-1:0] waddr,
    input  logic [HDATA_SIZE/8-1:0]      wmask,
    input  logic [HDATA_SIZE-1:0]        wdata,
    input  logic                         re,
    input  logic [$clog2(MEM_DEPTH)-1:0] raddr,
    output logic [HDATA_SIZE-1:0]        rdata
);

    logic [HDATA_SIZE-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        for (int b = 0; b < HDATA_SIZE/8; b++) begin
            if (we && wmask[b]) begin
                mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ahb3lite_sram_slave_ws.sv
// rtl/ahb3lite_sram_slave_ws.sv - AHB3-Lite SRAM slave with lanes, wait states, ERROR and bypass
// Purpose: decodes AHB3-Lite address phases into a lane-masked SRAM bank,
//          inserting WAIT_STATES wait cycles per OKAY transfer and a
//          two-cycle ERROR response for bad accesses.
// Ports:   HCLK/HRESET (sync, active high); HSEL/HADDR/HWRITE/HSIZE/HTRANS/
//          HBURST/HPROT/HREADY address-phase inputs; HWDATA write data;
//          HRDATA/HREADYOUT/HRESP data-phase outputs.
module ahb3lite_sram_slave_ws
    import ahb3lite_pkg::*;
#(
    parameter int                    HADDR_SIZE  = 32,
    parameter int                    HDATA_SIZE  = 32,
    parameter int                    MEM_DEPTH   = 256,
    parameter logic [HADDR_SIZE-1:0] BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [HADDR_SIZE-1:0] HADDR,
    input  logic [HDATA_SIZE-1:0] HWDATA,
    output logic [HDATA_SIZE-1:0] HRDATA,
    input  logic                  HWRITE,
    input  logic [2:0]            HSIZE,
    input  logic [2:0]            HBURST,
    input  logic [3:0]            HPROT,
    input  logic [1:0]            HTRANS,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP
);

    localparam int BYTES  = HDATA_SIZE / 8;
    localparam int LANE_W = $clog2(BYTES);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam logic [HADDR_SIZE:0] ADDR_LO  = {1'b0, BASE_ADDR};
    localparam logic [HADDR_SIZE:0] ADDR_HI  = ADDR_LO + (HADDR_SIZE+1)'(MEM_DEPTH * BYTES);
    localparam logic [2:0]          MAX_SIZE = (HDATA_SIZE == 64) ? HSIZE_DWORD : HSIZE_WORD;
    localparam logic [2:0]          WS_INIT  = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    slave_state_t          state;
    logic [2:0]            wait_cnt;
    logic                  hreadyout_q, hresp_q;
    logic                  pend_valid, pend_write;
    logic [IDX_W-1:0]      pend_idx;
    logic [BYTES-1:0]      pend_mask;
    logic                  byp_valid;
    logic [HDATA_SIZE-1:0] byp_data, byp_bits, merged, bank_rdata, hrdata_q;
    logic [BYTES-1:0]      byp_mask;

    logic [HADDR_SIZE:0] addr_ext;
    logic                range_err, size_err, align_err, dec_err;
    logic [7:0]          align_mask;
    logic [BYTES-1:0]    dec_mask;
    logic [IDX_W-1:0]    dec_idx;
    logic [LANE_W-1:0]   lane_off;
    logic                accept, completing, wr_done, rd_done, byp_hit;

    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT};

    always_comb begin
        addr_ext   = {1'b0, HADDR};
        range_err  = (addr_ext < ADDR_LO) || (addr_ext >= ADDR_HI);
        size_err   = HSIZE > MAX_SIZE;
        align_mask = (8'd1 << HSIZE) - 8'd1;
        align_err  = (HADDR[7:0] & align_mask) != 8'd0;
        dec_err    = range_err | size_err | align_err;
        lane_off   = HADDR[LANE_W-1:0];
        dec_mask   = '0;
        for (int b = 0; b < BYTES; b++) begin
            if (b >= int'(lane_off) && b < int'(lane_off) + (1 << HSIZE)) begin
                dec_mask[b] = 1'b1;
            end
        end
        // BASE_ADDR is aligned to the region size, so the raw address bits
        // above the lane offset already equal (HADDR - BASE_ADDR) >> LANE_W.
        dec_idx = HADDR[LANE_W +: IDX_W];
    end

    // Only IDLE and ERR2 present HREADYOUT=1, so only they may take a new address phase.
    assign accept = HSEL && HREADY && (htrans_t'(HTRANS) inside {HTRANS_NONSEQ, HTRANS_SEQ})
                    && (state == ST_IDLE || state == ST_ERR2);
    assign completing = pend_valid && (state == ST_IDLE);
    assign wr_done    = completing && pend_write;
    assign rd_done    = completing && !pend_write;
    // A read decoded while the previous write completes would see the old word in the bank.
    assign byp_hit    = accept && !dec_err && !HWRITE && wr_done && (dec_idx == pend_idx);

    always_comb begin
        byp_bits = '0;
        for (int b = 0; b < BYTES; b++) begin
            byp_bits[b*8 +: 8] = {8{byp_valid & byp_mask[b]}};
        end
        merged = (bank_rdata & ~byp_bits) | (byp_data & byp_bits);
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= ST_IDLE;
            wait_cnt    <= 3'd0;
            hreadyout_q <= 1'b1;
            hresp_q     <= HRESP_OKAY;
            pend_valid  <= 1'b0;
            pend_write  <= 1'b0;
            pend_idx    <= '0;
            pend_mask   <= '0;
            byp_valid   <= 1'b0;
            byp_data    <= '0;
            byp_mask    <= '0;
            hrdata_q    <= '0;
        end else begin
            if (rd_done) begin
                hrdata_q <= merged;
            end
            if (accept) begin
                pend_valid <= !dec_err;
                pend_write <= HWRITE;
                pend_idx   <= dec_idx;
                pend_mask  <= dec_mask;
                byp_valid  <= byp_hit;
                byp_data   <= HWDATA;
                byp_mask   <= pend_mask;
                if (dec_err && !HWRITE) begin
                    hrdata_q <= '0;
                end
            end else if (completing) begin
                pend_valid <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_ERR2: begin
                    if (accept && dec_err) begin
                        state       <= ST_ERR1;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_ERROR;
                    end else if (accept && WAIT_STATES > 0) begin
                        state       <= ST_WAIT;
                        wait_cnt    <= WS_INIT;
                        hreadyout_q <= 1'b0;
                        hresp_q     <= HRESP_OKAY;
                    end else begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                        hresp_q     <= HRESP_OKAY;
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state       <= ST_IDLE;
                        hreadyout_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                ST_ERR1: begin
                    state       <= ST_ERR2;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_ERROR;
                end
                default: begin
                    state       <= ST_IDLE;
                    hreadyout_q <= 1'b1;
                    hresp_q     <= HRESP_OKAY;
                end
            endcase
        end
    end

    ahb3lite_sram_bank #(
        .HDATA_SIZE (HDATA_SIZE),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_bank (
        .clk   (HCLK),
        .we    (wr_done && !HRESET),
        .waddr (pend_idx),
        .wmask (pend_mask),
        .wdata (HWDATA),
        .re    (accept && !dec_err && !HWRITE),
        .raddr (dec_idx),
        .rdata (bank_rdata)
    );

    assign HRDATA    = rd_done ? merged : hrdata_q;
    assign HREADYOUT = hreadyout_q;
    assign HRESP     = hresp_q;

endmodule

// File: tb/tb_ahb3lite_sram_slave_ws.sv
// tb/tb_ahb3lite_sram_slave_ws.sv - directed bench for ahb3lite_sram_slave_ws (0 and 3 wait states)
module tb_ahb3lite_sram_slave_ws;
    import ahb3lite_pkg::*;

    logic        hclk = 1'b0;
    always #5 hclk = ~hclk;

    logic        hreset, hsel, use3, hwrite;
    logic [31:0] haddr, hwdata;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic [1:0]  htrans;
    logic        sel0, sel3, ro0, ro3, resp0, resp3;
    logic [31:0] rdata0, rdata3;
    logic        cur_ro, cur_resp;
    logic [31:0] cur_rdata;

    int n_checks = 0;
    int n_pass   = 0;

    assign sel0      = hsel & ~use3;
    assign sel3      = hsel & use3;
    assign cur_ro    = use3 ? ro3 : ro0;
    assign cur_resp  = use3 ? resp3 : resp0;
    assign cur_rdata = use3 ? rdata3 : rdata0;

    ahb3lite_sram_slave_ws #(.WAIT_STATES(0)) u_ws0 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(sel0), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(rdata0), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(ro0), .HREADYOUT(ro0), .HRESP(resp0)
    );

    ahb3lite_sram_slave_ws #(.WAIT_STATES(3)) u_ws3 (
        .HCLK(hclk), .HRESET(hreset), .HSEL(sel3), .HADDR(haddr), .HWDATA(hwdata),
        .HRDATA(rdata3), .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
        .HTRANS(htrans), .HREADY(ro3), .HREADYOUT(ro3), .HRESP(resp3)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic addr_phase(input logic wr, input logic [31:0] a, input logic [2:0] sz);
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = wr;
        haddr  = a;
        hsize  = sz;
    endtask

    task automatic bus_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
    endtask

    // One isolated transfer; returns at the negedge of its completing cycle.
    task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, output logic [31:0] rd, output int waits,
                           output logic resp_wait, output logic resp_end);
        @(posedge hclk); #1;
        addr_phase(wr, a, sz);
        @(posedge hclk); #1;
        bus_idle();
        hwdata    = wd;
        waits     = 0;
        resp_wait = 1'b0;
        resp_end  = 1'b0;
        rd        = '0;
        forever begin
            @(negedge hclk);
            if (cur_ro) begin
                rd       = cur_rdata;
                resp_end = cur_resp;
                break;
            end
            resp_wait = resp_wait | cur_resp;
            waits++;
            if (waits > 20) begin
                check("xfer_timeout", 32'(waits), 32'd0);
                break;
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int          w;
        logic        rw, re;

        // Reset with a NONSEQ write on the bus
        hreset = 1'b1; use3 = 1'b0; hburst = 3'd0; hprot = 4'd0;
        hwdata = 32'hFFFF_FFFF;
        addr_phase(1'b1, 32'h40, HSIZE_WORD);
        repeat (3) @(posedge hclk);
        @(negedge hclk);
        check("rst_ready0", 32'(ro0), 32'd1);
        check("rst_resp0", 32'(resp0), 32'd0);
        check("rst_rdata0", rdata0, 32'd0);
        check("rst_ready3", 32'(ro3), 32'd1);
        check("rst_rdata3", rdata3, 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        bus_idle();

        // Reset does not write memory
        do_xfer(1'b1, 32'h40, HSIZE_WORD, 32'h0102_0304, rd, w, rw, re);
        @(posedge hclk); #1;
        hreset = 1'b1;
        hwdata = 32'hFFFF_FFFF;
        addr_phase(1'b1, 32'h40, HSIZE_WORD);
        repeat (3) @(posedge hclk);
        #1;
        hreset = 1'b0;
        bus_idle();
        do_xfer(1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, w, rw, re);
        check("rst_nowrite", rd, 32'h0102_0304);

        // Back-to-back write then read of the same word (bypass)
        @(posedge hclk); #1;
        addr_phase(1'b1, 32'h10, HSIZE_WORD);
        @(posedge hclk); #1;
        hwdata = 32'hDEAD_BEEF;
        addr_phase(1'b0, 32'h10, HSIZE_WORD);
        @(negedge hclk);
        check("byp_wr_ready", 32'(ro0), 32'd1);
        @(posedge hclk); #1;
        bus_idle();
        @(negedge hclk);
        check("byp_rd_ready", 32'(ro0), 32'd1);
        check("byp_rd_resp", 32'(resp0), 32'd0);
        check("byp_rdata", rdata0, 32'hDEAD_BEEF);

        // Byte lanes, zero wait states
        do_xfer(1'b1, 32'h20, HSIZE_WORD, 32'h1122_3344, rd, w, rw, re);
        check("ws0_write_waits", 32'(w), 32'd0);
        do_xfer(1'b1, 32'h21, HSIZE_BYTE, 32'h0000_AA00, rd, w, rw, re);
        do_xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, rd, w, rw, re);
        check("lane_word", rd, 32'h1122_AA44);
        do_xfer(1'b0, 32'h22, HSIZE_HWORD, 32'h0, rd, w, rw, re);
        check("lane_hword_hi", 32'(rd[31:16]), 32'h1122);
        do_xfer(1'b0, 32'h20, 3'd3, 32'h0, rd, w, rw, re);
        check("ws0_err_waits", 32'(w), 32'd1);
        check("ws0_err_resp", 32'(re), 32'd1);

        // Three wait states
        use3 = 1'b1;
        do_xfer(1'b1, 32'h20, HSIZE_WORD, 32'h1122_AA44, rd, w, rw, re);
        check("ws3_write_waits", 32'(w), 32'd3);
        do_xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, rd, w, rw, re);
        check("ws3_read_waits", 32'(w), 32'd3);
        check("ws3_read_data", rd, 32'h1122_AA44);
        check("ws3_read_resp", 32'(re | rw), 32'd0);

        // Error responses (WS=3 still gives exactly two cycles)
        do_xfer(1'b1, 32'h00, HSIZE_WORD, 32'h55AA_55AA, rd, w, rw, re);
        do_xfer(1'b1, 32'h30, HSIZE_WORD, 32'hA5A5_A5A5, rd, w, rw, re);

        do_xfer(1'b1, 32'h400, HSIZE_WORD, 32'hBAD0_BAD0, rd, w, rw, re);
        check("oor_waits", 32'(w), 32'd1);
        check("oor_err1_resp", 32'(rw), 32'd1);
        check("oor_err2_resp", 32'(re), 32'd1);
        do_xfer(1'b0, 32'h400, HSIZE_WORD, 32'h0, rd, w, rw, re);
        check("oor_read_rdata", rd, 32'd0);
        do_xfer(1'b0, 32'h00, HSIZE_WORD, 32'h0, rd, w, rw, re);
        check("oor_after_resp", 32'(re), 32'd0);
        check("oor_after_waits", 32'(w), 32'd3);
        check("oor_mem", rd, 32'h55AA_55AA);

        do_xfer(1'b1, 32'h31, HSIZE_HWORD, 32'hFFFF_FFFF, rd, w, rw, re);
        check("misal_waits", 32'(w), 32'd1);
        check("misal_err1_resp", 32'(rw), 32'd1);
        check("misal_err2_resp", 32'(re), 32'd1);
        do_xfer(1'b0, 32'h30, HSIZE_WORD, 32'h0, rd, w, rw, re);
        check("misal_after_resp", 32'(re), 32'd0);
        check("misal_mem", rd, 32'hA5A5_A5A5);

        do_xfer(1'b1, 32'h30, 3'd3, 32'h0000_0000, rd, w, rw, re);
        check("size_waits", 32'(w), 32'd1);
        check("size_err1_resp", 32'(rw), 32'd1);
        check("size_err2_resp", 32'(re), 32'd1);
        do_xfer(1'b0, 32'h30, HSIZE_WORD, 32'h0, rd, w, rw, re);
        check("size_after_resp", 32'(re), 32'd0);
        check("size_mem", rd, 32'hA5A5_A5A5);

        // Reset during the second wait cycle of a write
        do_xfer(1'b1, 32'h50, HSIZE_WORD, 32'hCAFE_F00D, rd, w, rw, re);
        @(posedge hclk); #1;
        addr_phase(1'b1, 32'h50, HSIZE_WORD);
        @(posedge hclk); #1;
        bus_idle();
        hwdata = 32'h1234_5678;
        @(negedge hclk);
        check("midrst_wait1", 32'(ro3), 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b1;
        @(negedge hclk);
        check("midrst_wait2", 32'(ro3), 32'd0);
        @(posedge hclk); #1;
        hreset = 1'b0;
        @(negedge hclk);
        check("midrst_ready", 32'(ro3), 32'd1);
        check("midrst_resp", 32'(resp3), 32'd0);
        do_xfer(1'b0, 32'h50, HSIZE_WORD, 32'h0, rd, w, rw, re);
        check("midrst_mem", rd, 32'hCAFE_F00D);

        @(posedge hclk); #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
